// File: rtl/handshake_eager_fork.sv
// handshake_eager_fork: replicates one elastic token to SIZE consumers.
// Each consumer may take the token in a different cycle; the input token
// retires only once every consumer has taken it exactly once.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset (clears emitted bits)
//   ins        - input token data
//   ins_valid  - input token valid
//   ins_ready  - input token accepted this cycle (combinational)
//   outs       - replicated data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   outs_valid - per-channel valid (combinational)
//   outs_ready - per-channel ready
module handshake_eager_fork #(
    parameter int unsigned SIZE       = 2,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        ins,
    input  logic                         ins_valid,
    output logic                         ins_ready,
    output logic [SIZE*DATA_WIDTH-1:0]   outs,
    output logic [SIZE-1:0]              outs_valid,
    input  logic [SIZE-1:0]              outs_ready
);

    // emitted[i] = channel i has already taken the current token
    logic [SIZE-1:0] emitted;
    logic [SIZE-1:0] emitted_next;
    logic [SIZE-1:0] done;
    logic [SIZE-1:0] xfer;

    // Data is a pure fan-out wire
    assign outs = {SIZE{ins}};

    // Handshake and next-emitted logic; retire wins over per-channel set
    always_comb begin
        outs_valid   = '0;
        done         = '0;
        xfer         = '0;
        ins_ready    = 1'b0;
        emitted_next = emitted;

        outs_valid = {SIZE{ins_valid}} & ~emitted;
        done       = emitted | outs_ready;
        ins_ready  = &done;
        xfer       = outs_valid & outs_ready;

        if (ins_valid && ins_ready) begin
            emitted_next = '0;
        end else begin
            emitted_next = emitted | xfer;
        end
    end

    // Emitted-bit register
    always_ff @(posedge clk) begin
        if (rst) begin
            emitted <= '0;
        end else begin
            emitted <= emitted_next;
        end
    end

endmodule

// File: tb/tb_handshake_eager_fork.sv
// tb_handshake_eager_fork: directed self-checking bench for the eager fork,
// covering SIZE=2, SIZE=3 and SIZE=1 instances.
module tb_handshake_eager_fork;

    localparam int unsigned DW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // SIZE=2 instance
    logic [DW-1:0]   ins2 = '0;
    logic            ins_valid2 = 1'b0;
    logic            ins_ready2;
    logic [2*DW-1:0] outs2;
    logic [1:0]      outs_valid2;
    logic [1:0]      outs_ready2 = '0;

    // SIZE=3 instance
    logic [DW-1:0]   ins3 = '0;
    logic            ins_valid3 = 1'b0;
    logic            ins_ready3;
    logic [3*DW-1:0] outs3;
    logic [2:0]      outs_valid3;
    logic [2:0]      outs_ready3 = '0;

    // SIZE=1 instance
    logic [DW-1:0]   ins1 = '0;
    logic            ins_valid1 = 1'b0;
    logic            ins_ready1;
    logic [DW-1:0]   outs1;
    logic [0:0]      outs_valid1;
    logic [0:0]      outs_ready1 = '0;

    handshake_eager_fork #(.SIZE(2), .DATA_WIDTH(DW)) u_fork2 (
        .clk(clk), .rst(rst), .ins(ins2), .ins_valid(ins_valid2),
        .ins_ready(ins_ready2), .outs(outs2), .outs_valid(outs_valid2),
        .outs_ready(outs_ready2)
    );

    handshake_eager_fork #(.SIZE(3), .DATA_WIDTH(DW)) u_fork3 (
        .clk(clk), .rst(rst), .ins(ins3), .ins_valid(ins_valid3),
        .ins_ready(ins_ready3), .outs(outs3), .outs_valid(outs_valid3),
        .outs_ready(outs_ready3)
    );

    handshake_eager_fork #(.SIZE(1), .DATA_WIDTH(DW)) u_fork1 (
        .clk(clk), .rst(rst), .ins(ins1), .ins_valid(ins_valid1),
        .ins_ready(ins_ready1), .outs(outs1), .outs_valid(outs_valid1),
        .outs_ready(outs_ready1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int tx0;
    int tx1;
    int tx2;
    int retired;
    logic [2:0] xf3;
    logic       rv;
    logic       rr;
    logic [DW-1:0] rd;

    initial begin
        // 1. Reset output values (SIZE=2)
        ins2        = 12'hFAF;
        ins_valid2  = 1'b1;
        outs_ready2 = 2'b00;
        rst         = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            check("rst_valid", 64'(outs_valid2), 64'h3);
            check("rst_outs", 64'(outs2), 64'hFAF_FAF);
            check("rst_ready", 64'(ins_ready2), 64'h0);
        end
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_valid", 64'(outs_valid2), 64'h3);

        // 2. Full acceptance: 4 tokens, one per cycle
        tx0 = 0; tx1 = 0; retired = 0;
        outs_ready2 = 2'b11;
        for (int c = 0; c < 4; c++) begin
            tick();
            #1;
            check("full_ready", 64'(ins_ready2), 64'h1);
            check("full_valid", 64'(outs_valid2), 64'h3);
            check("full_outs", 64'(outs2), 64'hFAF_FAF);
            if (outs_valid2[0] && outs_ready2[0]) tx0++;
            if (outs_valid2[1] && outs_ready2[1]) tx1++;
            if (ins_valid2 && ins_ready2) retired++;
        end
        check("full_tx0", 64'(tx0), 64'd4);
        check("full_tx1", 64'(tx1), 64'd4);
        check("full_retired", 64'(retired), 64'd4);

        // 4. Input stall with channel 0 already emitted
        tick();
        outs_ready2 = 2'b01;
        #1;
        check("part_ready", 64'(ins_ready2), 64'h0);
        tick();
        ins_valid2  = 1'b0;
        outs_ready2 = 2'b11;
        #1;
        check("stall_valid", 64'(outs_valid2), 64'h0);
        check("stall_ready", 64'(ins_ready2), 64'h1);
        tick();
        ins_valid2  = 1'b1;
        outs_ready2 = 2'b00;
        #1;
        check("stall_hold", 64'(outs_valid2), 64'h2);

        // 5. Reset mid-token re-offers to every channel
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_valid", 64'(outs_valid2), 64'h3);
        check("midrst_outs0", 64'(outs2[DW-1:0]), 64'hFAF);
        tick();
        outs_ready2 = 2'b11;
        #1;
        check("midrst_retire", 64'(ins_ready2), 64'h1);
        tick();
        ins_valid2  = 1'b0;
        outs_ready2 = 2'b00;

        // 3. Staggered acceptance (SIZE=3)
        ins3 = 12'h5A3;
        ins_valid3 = 1'b1;
        tx0 = 0; tx1 = 0; tx2 = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            case (c)
                0: outs_ready3 = 3'b001;
                1: outs_ready3 = 3'b100;
                2: outs_ready3 = 3'b010;
                default: outs_ready3 = 3'b000;
            endcase
            #1;
            xf3 = outs_valid3 & outs_ready3;
            if (xf3[0]) tx0++;
            if (xf3[1]) tx1++;
            if (xf3[2]) tx2++;
            case (c)
                0: begin
                    check("stag0_valid", 64'(outs_valid3), 64'h7);
                    check("stag0_ready", 64'(ins_ready3), 64'h0);
                end
                1: begin
                    check("stag1_valid", 64'(outs_valid3), 64'h6);
                    check("stag1_ready", 64'(ins_ready3), 64'h0);
                end
                2: begin
                    check("stag2_valid", 64'(outs_valid3), 64'h2);
                    check("stag2_ready", 64'(ins_ready3), 64'h1);
                end
                default: begin
                    check("stag3_valid", 64'(outs_valid3), 64'h7);
                    check("stag3_outs", 64'(outs3), 64'h5A3_5A3_5A3);
                end
            endcase
        end
        check("stag_tx0", 64'(tx0), 64'd1);
        check("stag_tx1", 64'(tx1), 64'd1);
        check("stag_tx2", 64'(tx2), 64'd1);
        tick();
        ins_valid3 = 1'b0;

        // 6. SIZE=1 random handshake
        for (int c = 0; c < 200; c++) begin
            tick();
            rv = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            rd = DW'($urandom);
            ins_valid1  = rv;
            outs_ready1 = rr;
            ins1        = rd;
            #1;
            check("s1_ready", 64'(ins_ready1), 64'(rr));
            check("s1_valid", 64'(outs_valid1), 64'(rv));
            check("s1_outs", 64'(outs1), 64'(rd));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
